// File: rtl/lisnoc_router_input_port_pkg.sv
// lisnoc_router_input_port_pkg: flit type encoding shared by the router input port files
package lisnoc_router_input_port_pkg;
    typedef enum logic [1:0] {
        FLIT_PAYLOAD = 2'b00,
        FLIT_HEADER  = 2'b01,
        FLIT_LAST    = 2'b10,
        FLIT_SINGLE  = 2'b11
    } flit_type_t;
    localparam int FLIT_TYPE_BITS = 2;
    function automatic logic starts_packet(input flit_type_t t);
        return t == FLIT_HEADER || t == FLIT_SINGLE;
    endfunction
endpackage

// File: rtl/lisnoc_fifo.sv
// lisnoc_fifo: per-vchannel flit buffer; head is registered, so a write shows up the next cycle.
module lisnoc_fifo #(
    parameter int flit_width = 34,
    parameter int length     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [flit_width-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [flit_width-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_read
);
    localparam int aw = (length > 1) ? $clog2(length) : 1;
    localparam int cw = $clog2(length + 1);
    logic [flit_width-1:0] mem_q [length];
    logic [flit_width-1:0] mem_d [length];
    logic [aw-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [cw-1:0] cnt_q, cnt_d;
    logic en_q, push, pop;
    // Fullness ignores a same-cycle read: a full FIFO never accepts a write.
    always_comb begin
        in_ready  = en_q && cnt_q != cw'(length);
        out_valid = cnt_q != '0;
        out_flit  = out_valid ? mem_q[rd_q] : '0;
        push      = in_valid && in_ready;
        pop       = out_read && out_valid;
        mem_d     = mem_q;
        if (push) mem_d[wr_q] = in_flit;
        wr_d  = push ? ((wr_q == aw'(length - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d  = pop ? ((rd_q == aw'(length - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + cw'(push) - cw'(pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            en_q  <= 1'b1;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/lisnoc_router_input_port_route.sv
// lisnoc_router_input_port_route: per-vchannel packet FSM, destination lookup, route hold and drop logic.
module lisnoc_router_input_port_route
    import lisnoc_router_input_port_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ph_dest_width   = 5,
    parameter int ph_dest_offset  = 27,
    parameter int ports           = 5,
    parameter logic [(1<<ph_dest_width)*ports-1:0] lookup = '0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [flit_data_width+flit_type_width-1:0] flit,
    input  logic                                       valid,
    input  logic                                       read,
    output logic [ports-1:0]                           request,
    output logic                                       consume,
    output logic                                       err
);
    localparam int flit_width = flit_data_width + flit_type_width;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DROP   = 2'd2;
    logic [1:0] state_q, state_d;
    logic [ports-1:0] route_q, route_d, r;
    logic [ph_dest_width-1:0] dest;
    flit_type_t ftype;
    logic unused_bits;
    assign unused_bits = ^flit;
    always_comb begin
        ftype   = flit_type_t'(flit[flit_width-1 -: FLIT_TYPE_BITS]);
        dest    = flit[ph_dest_offset +: ph_dest_width];
        r       = lookup[dest*ports +: ports];
        state_d = state_q;
        route_d = route_q;
        request = '0;
        consume = 1'b0;
        err     = 1'b0;
        if (valid) begin
            if (state_q == ACTIVE) begin
                request = route_q;
                consume = read;
                if (read && ftype == FLIT_LAST) state_d = IDLE;
            end else if (state_q == DROP) begin
                consume = 1'b1;
                err     = 1'b1;
                if (ftype == FLIT_LAST) state_d = IDLE;
            end else if (starts_packet(ftype) && r != '0) begin
                request = r;
                consume = read;
                if (read && ftype == FLIT_HEADER) begin
                    state_d = ACTIVE;
                    route_d = r;
                end
            end else begin
                // unroutable heads and stray body flits are discarded without a request
                consume = 1'b1;
                err     = 1'b1;
                if (ftype == FLIT_HEADER) state_d = DROP;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end
endmodule

// File: rtl/lisnoc_router_input_port.sv
// lisnoc_router_input_port: per-vchannel input buffering and routing toward the switch.
// Define LISNOC_ROUTER_INPUT_ERRCNT_EN to count dropped flits on error_count.
module lisnoc_router_input_port
    import lisnoc_router_input_port_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ph_dest_width   = 5,
    parameter int ph_dest_offset  = 27,
    parameter int vchannels       = 1,
    parameter int ports           = 5,
    parameter int fifo_length     = 4,
    parameter logic [(1<<ph_dest_width)*ports-1:0] lookup = '0
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [flit_data_width+flit_type_width-1:0]           link_flit,
    input  logic [vchannels-1:0]                                 link_valid,
    output logic [vchannels-1:0]                                 link_ready,
    output logic [vchannels*ports-1:0]                           switch_request,
    output logic [vchannels*(flit_data_width+flit_type_width)-1:0] switch_flit,
    input  logic [vchannels*ports-1:0]                           switch_read,
    output logic [15:0]                                          error_count
);
    localparam int flit_width = flit_data_width + flit_type_width;
    logic [vchannels-1:0] err, head_valid, consume;
    logic [flit_width-1:0] head [vchannels];
    for (genvar v = 0; v < vchannels; v++) begin : g_vc
        lisnoc_fifo #(
            .flit_width(flit_width),
            .length    (fifo_length)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .in_flit  (link_flit),
            .in_valid (link_valid[v]),
            .in_ready (link_ready[v]),
            .out_flit (head[v]),
            .out_valid(head_valid[v]),
            .out_read (consume[v])
        );
        assign switch_flit[v*flit_width +: flit_width] = head[v];
        lisnoc_router_input_port_route #(
            .flit_data_width(flit_data_width),
            .flit_type_width(flit_type_width),
            .ph_dest_width  (ph_dest_width),
            .ph_dest_offset (ph_dest_offset),
            .ports          (ports),
            .lookup         (lookup)
        ) u_route (
            .clk    (clk),
            .rst    (rst),
            .flit   (head[v]),
            .valid  (head_valid[v]),
            .read   (|switch_read[v*ports +: ports]),
            .request(switch_request[v*ports +: ports]),
            .consume(consume[v]),
            .err    (err[v])
        );
    end
`ifdef LISNOC_ROUTER_INPUT_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;
    always_comb begin
        err_sum = {1'b0, err_cnt_q};
        for (int i = 0; i < vchannels; i++) err_sum = err_sum + 17'(err[i]);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt_q <= '0;
        else err_cnt_q <= err_cnt_d;
    end
    assign error_count = err_cnt_q;
`else
    logic unused_err;
    assign unused_err  = ^err;
    assign error_count = '0;
`endif
endmodule

// File: tb/tb_lisnoc_router_input_port.sv
// tb_lisnoc_router_input_port: randomized packet stimulus with a packet-level scoreboard for the router input port.
module tb_lisnoc_router_input_port;
    localparam int V  = 2;
    localparam int P  = 5;
    localparam int DW = 32;
    localparam int FW = 34;
    localparam logic [1:0] T_PAY = 2'b00, T_HDR = 2'b01, T_LAST = 2'b10, T_SGL = 2'b11;

    function automatic logic [P-1:0] route_of(input int d);
        if (d == 3) return 5'b00100;
        if (d == 1) return 5'b00001;
        if (d % 7 == 0) return '0;
        return P'(1 << (d % P));
    endfunction
    function automatic logic [32*P-1:0] mk_lookup();
        logic [32*P-1:0] t;
        t = '0;
        for (int d = 0; d < 32; d++) t[d*P +: P] = route_of(d);
        return t;
    endfunction
    localparam logic [32*P-1:0] LOOKUP = mk_lookup();

    typedef struct {
        logic [P-1:0]  route;
        logic [FW-1:0] flit;
    } exp_t;

    logic clk, rst;
    logic [FW-1:0] link_flit;
    logic [V-1:0] link_valid, link_ready;
    logic [V*P-1:0] switch_request, switch_read;
    logic [V*FW-1:0] switch_flit;
    logic [15:0] error_count;

    lisnoc_router_input_port #(
        .vchannels(V),
        .ports    (P),
        .lookup   (LOOKUP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .link_flit     (link_flit),
        .link_valid    (link_valid),
        .link_ready    (link_ready),
        .switch_request(switch_request),
        .switch_flit   (switch_flit),
        .switch_read   (switch_read),
        .error_count   (error_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0, checks = 0, bubbles = 0, err_exp = 0, gnt_pct = 100;
    logic [V-1:0] gnt_en = '0;
    exp_t expq [V][$];
    logic [FW-1:0] pend [V][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic int exp_err();
`ifdef LISNOC_ROUTER_INPUT_ERRCNT_EN
        return err_exp > 65535 ? 65535 : err_exp;
`else
        return 0;
`endif
    endfunction

    // Packet-level model: a routable packet forwards every flit with the header's route, an unroutable one drops all.
    task automatic add_packet(input int v, input logic [1:0] ht, input int dest, input int nmid);
        logic [P-1:0] r;
        logic [DW-1:0] d;
        logic [1:0] t;
        int n, c;
        r = route_of(dest);
        n = (ht == T_SGL) ? 1 : nmid + 2;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            c = $urandom_range(7);
            if (i == 0) begin
                t = ht;
                d[31:27] = 5'(dest);
            end else if (i == n - 1) t = T_LAST;
            else t = (c == 0) ? T_HDR : (c == 1) ? T_SGL : T_PAY;
            pend[v].push_back({t, d});
            if (r != '0) expq[v].push_back('{r, {t, d}});
            else err_exp++;
        end
    endtask

    task automatic add_stray(input int v, input logic [1:0] t);
        logic [DW-1:0] d;
        d = $urandom;
        pend[v].push_back({t, d});
        err_exp++;
    endtask

    task automatic send(input int v, input logic [FW-1:0] f);
        int n;
        n = 0;
        @(negedge clk);
        link_flit = f;
        link_valid = '0;
        link_valid[v] = 1'b1;
        while (!link_ready[v] && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!link_ready[v]) begin
            errors++;
            $display("FAIL send_timeout vc%0d: link_ready got 0 for %0d cycles, required 1", v, n);
        end else @(posedge clk);
        #1 link_valid = '0;
    endtask

    function automatic bit pending(input logic [V-1:0] mask);
        for (int v = 0; v < V; v++) if (mask[v] && pend[v].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic flush(input logic [V-1:0] mask);
        int v;
        while (pending(mask)) begin
            do v = $urandom_range(V - 1); while (!(mask[v] && pend[v].size() != 0));
            if ($urandom_range(3) == 0) @(negedge clk);
            send(v, pend[v].pop_front());
        end
    endtask

    task automatic wait_drain(input logic [V-1:0] mask);
        int n, left;
        n = 0;
        forever begin
            left = 0;
            for (int v = 0; v < V; v++) if (mask[v]) left += expq[v].size();
            if (left == 0 || n >= 2000) break;
            @(negedge clk);
            n++;
        end
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d flits outstanding, required 0", left);
        end
        repeat (6) @(negedge clk);
    endtask

    // Switch model and scoreboard monitor: grants pending requests and checks each granted flit.
    initial begin
        logic [P-1:0] req;
        exp_t e;
        switch_read = '0;
        forever begin
            @(negedge clk);
            switch_read = '0;
            for (int v = 0; v < V; v++) begin
                req = switch_request[v*P +: P];
                if (gnt_en[v] && req == '0 && expq[v].size() != 0) bubbles++;
                if (gnt_en[v] && req != '0 && $urandom_range(99) < gnt_pct) begin
                    checks++;
                    if (expq[v].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_req vc%0d: got request %b flit %h, required no request", v, req, switch_flit[v*FW +: FW]);
                    end else begin
                        e = expq[v].pop_front();
                        if (req !== e.route || switch_flit[v*FW +: FW] !== e.flit) begin
                            errors++;
                            $display("FAIL forward vc%0d: got %b/%h required %b/%h", v, req, switch_flit[v*FW +: FW], e.route, e.flit);
                        end
                    end
                    switch_read[v*P +: P] = req;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int v, c;
        rst = 1'b0;
        link_flit = '0;
        link_valid = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(link_ready), 0);
        chk("reset_request", 64'(switch_request), 0);
        chk("reset_flit_zero", 64'(switch_flit != '0), 0);
        chk("reset_errcnt", 64'(error_count), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(link_ready), 64'(2'b11));
        chk("release_request", 64'(switch_request), 0);

        // routed packet, one-cycle link-to-request latency
        add_packet(0, T_HDR, 3, 1);
        send(0, pend[0].pop_front());
        gnt_en[0] = 1'b1;
        @(negedge clk);
        chk("header_latency", 64'(switch_request[P-1:0]), 64'(5'b00100));
        flush(2'b01);
        wait_drain(2'b11);

        // single-flit packet requests for exactly one cycle
        add_packet(0, T_SGL, 1, 0);
        send(0, pend[0].pop_front());
        @(negedge clk);
        chk("single_request", 64'(switch_request[P-1:0]), 64'(5'b00001));
        @(negedge clk);
        chk("single_released", 64'(switch_request[P-1:0]), 0);
        wait_drain(2'b11);

        // backpressure: six flits into a four-deep FIFO
        gnt_en = '0;
        add_packet(0, T_HDR, 2, 4);
        repeat (4) send(0, pend[0].pop_front());
        @(negedge clk);
        chk("full_not_ready", 64'(link_ready[0]), 0);
        gnt_en[0] = 1'b1;
        flush(2'b01);
        wait_drain(2'b11);

        // header queued behind a LAST is requested with no bubble
        gnt_en = '0;
        add_packet(0, T_HDR, 3, 0);
        add_packet(0, T_HDR, 2, 0);
        flush(2'b01);
        bubbles = 0;
        gnt_en[0] = 1'b1;
        wait_drain(2'b11);
        chk("back_to_back_bubbles", 64'(bubbles), 0);

        // unroutable packet is dropped silently
        gnt_en = 2'b11;
        add_packet(0, T_HDR, 7, 2);
        flush(2'b01);
        wait_drain(2'b11);
        chk("drop_errcnt", 64'(error_count), 64'(exp_err()));
        chk("drop_no_request", 64'(switch_request), 0);

        // vc0 stalled with a full FIFO while vc1 streams
        gnt_en = 2'b10;
        add_packet(0, T_HDR, 5, 3);
        repeat (4) send(0, pend[0].pop_front());
        add_packet(1, T_HDR, 6, 3);
        flush(2'b10);
        wait_drain(2'b10);
        chk("vc0_stalled_ready", 64'(link_ready[0]), 0);
        chk("vc0_stalled_request", 64'(switch_request[P-1:0]), 64'(route_of(5)));
        gnt_en = 2'b11;
        flush(2'b11);
        wait_drain(2'b11);

        // reset in the middle of an active packet
        gnt_en = 2'b01;
        add_packet(0, T_HDR, 3, 2);
        repeat (2) send(0, pend[0].pop_front());
        gnt_en = '0;
        @(negedge clk);
        chk("pre_reset_request", 64'(switch_request[P-1:0]), 64'(5'b00100));
        rst = 1'b0;
        #1;
        chk("reset_mid_request", 64'(switch_request), 0);
        chk("reset_mid_ready", 64'(link_ready), 0);
        chk("reset_mid_errcnt", 64'(error_count), 0);
        for (int i = 0; i < V; i++) begin
            expq[i].delete();
            pend[i].delete();
        end
        err_exp = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_release_ready", 64'(link_ready), 64'(2'b11));
        chk("reset_mid_release_request", 64'(switch_request), 0);
        gnt_en = 2'b11;
        add_packet(0, T_HDR, 2, 1);
        flush(2'b01);
        wait_drain(2'b11);

        // randomized traffic on both vchannels with random grants
        gnt_pct = 60;
        for (int k = 0; k < 40; k++) begin
            v = $urandom_range(V - 1);
            c = $urandom_range(9);
            if (c == 0) add_stray(v, $urandom_range(1) ? T_PAY : T_LAST);
            else if (c < 3) add_packet(v, T_SGL, $urandom_range(31), 0);
            else add_packet(v, T_HDR, $urandom_range(31), $urandom_range(4));
        end
        flush(2'b11);
        wait_drain(2'b11);
        chk("random_errcnt", 64'(error_count), 64'(exp_err()));
        chk("random_idle_request", 64'(switch_request), 0);
        chk("random_idle_ready", 64'(link_ready), 64'(2'b11));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
